// File: rtl/gate_sweep_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : gate_sweep_ctrl
// Description : Exhaustive truth-table sequencer for a single-output gate.
//               Drives every input vector in ascending order, waits a settle
//               time, samples the gate and records per-vector mismatches.
// Revision    : 1.0 - initial release
// ============================================================================
module gate_sweep_ctrl #(
    parameter int                   N_IN   = 2,
    parameter int                   SETTLE = 1,
    parameter logic [(2**N_IN)-1:0] EXPECT = 4'b0001
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    output logic [N_IN-1:0]        gate_in,
    input  logic                   gate_out,
    output logic                   busy,
    output logic                   done,
    output logic                   pass,
    output logic [(2**N_IN)-1:0]   fail_vec,
    output logic [N_IN:0]          err_count
);

    localparam logic [3:0]      c_settle_init = 4'(SETTLE - 1);
    localparam logic [N_IN-1:0] c_vec_one     = N_IN'(1);
    localparam logic [N_IN-1:0] c_vec_last    = '1;
    localparam logic [N_IN:0]   c_err_one     = (N_IN + 1)'(1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    state_t                  state_q,     state_d;
    logic [3:0]              cnt_q,       cnt_d;
    logic [N_IN-1:0]         gate_in_q,   gate_in_d;
    logic                    busy_q,      busy_d;
    logic                    done_q,      done_d;
    logic                    pass_q,      pass_d;
    logic [(2**N_IN)-1:0]    fail_vec_q,  fail_vec_d;
    logic [N_IN:0]           err_count_q, err_count_d;
    logic                    w_mismatch;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 4'd0;
            gate_in_q   <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            fail_vec_q  <= '0;
            err_count_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            gate_in_q   <= gate_in_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            pass_q      <= pass_d;
            fail_vec_q  <= fail_vec_d;
            err_count_q <= err_count_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        gate_in_d   = gate_in_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        pass_d      = pass_q;
        fail_vec_d  = fail_vec_q;
        err_count_d = err_count_q;
        // Case inequality so an X or Z from the cell counts as a failure.
        w_mismatch  = (gate_out !== EXPECT[gate_in_q]);

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d     = ST_SETTLE;
                    gate_in_d   = '0;
                    busy_d      = 1'b1;
                    fail_vec_d  = '0;
                    err_count_d = '0;
                    pass_d      = 1'b0;
                    cnt_d       = c_settle_init;
                end
            end
            ST_SETTLE: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    state_d = ST_SAMPLE;
                end
            end
            ST_SAMPLE: begin
                if (w_mismatch) begin
                    fail_vec_d[gate_in_q] = 1'b1;
                    err_count_d           = err_count_q + c_err_one;
                end
                if (gate_in_q == c_vec_last) begin
                    state_d = ST_DONE;
                end else begin
                    gate_in_d = gate_in_q + c_vec_one;
                    cnt_d     = c_settle_init;
                    state_d   = ST_SETTLE;
                end
            end
            ST_DONE: begin
                // Results land on the edge leaving DONE, so done and the
                // busy drop appear together in the following IDLE cycle.
                done_d    = 1'b1;
                busy_d    = 1'b0;
                pass_d    = (err_count_q == '0);
                gate_in_d = '0;
                state_d   = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign gate_in   = gate_in_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign pass      = pass_q;
    assign fail_vec  = fail_vec_q;
    assign err_count = err_count_q;

endmodule
`default_nettype wire

// File: tb/tb_gate_sweep_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_gate_sweep_ctrl
// Description : Self-checking bench for gate_sweep_ctrl (two settle settings).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_gate_sweep_ctrl;

    localparam int         NI  = 2;
    localparam int         NV  = 4;
    localparam logic [3:0] EXP = 4'b0001;
    localparam int         ST [2] = '{1, 3};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                 reset;
    logic [1:0]           start;
    logic [1:0]           gout;
    logic [1:0][NI-1:0]   gi;
    logic [1:0]           busy, done, pass;
    logic [1:0][NV-1:0]   fv;
    logic [1:0][NI:0]     ec;

    int   tests = 0;
    int   fails = 0;
    int   cyc   = 0;
    int   t_acc = 0;
    int   mode  = 0;
    logic xsub;

    gate_sweep_ctrl #(.N_IN(2), .SETTLE(1), .EXPECT(4'b0001)) u_dut0 (
        .clk(clk), .reset(reset), .start(start[0]), .gate_in(gi[0]),
        .gate_out(gout[0]), .busy(busy[0]), .done(done[0]), .pass(pass[0]),
        .fail_vec(fv[0]), .err_count(ec[0])
    );

    gate_sweep_ctrl #(.N_IN(2), .SETTLE(3), .EXPECT(4'b0001)) u_dut1 (
        .clk(clk), .reset(reset), .start(start[1]), .gate_in(gi[1]),
        .gate_out(gout[1]), .busy(busy[1]), .done(done[1]), .pass(pass[1]),
        .fail_vec(fv[1]), .err_count(ec[1])
    );

    // Cells under test: 0 NOR, 1 stuck-at-0, 2 OR, 3 NOR with unknown on vector 1.
    always_comb begin
        case (mode)
            0:       gout[0] = ~|gi[0];
            1:       gout[0] = 1'b0;
            2:       gout[0] = |gi[0];
            default: gout[0] = (gi[0] == 2'd1) ? xsub : ~|gi[0];
        endcase
        gout[1] = ~|gi[1];
    end

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s at t=%0t: got %0h, want %0h", nm, $time, got, want);
        end
    endtask

    always @(posedge clk) cyc++;

    // Model: tracks edges since accept; each vector spans settle+1 edges,
    // its sample is the last of those, results publish one edge after.
    bit                 act [2];
    int                 n   [2];
    bit                 mvalid = 1'b0;
    logic [NI-1:0]      e_gi   [2];
    logic               e_busy [2], e_done [2], e_pass [2];
    logic [NV-1:0]      e_fv   [2];
    logic [NI:0]        e_ec   [2];

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            int per, last, v, g;
            per  = ST[i] + 1;
            last = NV * per;
            if (reset) begin
                act[i] = 0; n[i] = 0; e_gi[i] = '0; e_busy[i] = 0; e_done[i] = 0;
                e_pass[i] = 0; e_fv[i] = '0; e_ec[i] = '0;
            end else if (act[i]) begin
                n[i]++;
                e_done[i] = 0;
                if ((n[i] % per) == 0 && n[i] <= last) begin
                    v = n[i] / per - 1;
                    if (gout[i] !== EXP[v]) begin
                        e_fv[i][v] = 1'b1;
                        e_ec[i]    = e_ec[i] + 1'b1;
                    end
                end
                if (n[i] == last + 1) begin
                    act[i] = 0; e_done[i] = 1; e_busy[i] = 0;
                    e_pass[i] = (e_ec[i] == 0); e_gi[i] = '0;
                end else begin
                    g = n[i] / per;
                    if (g > NV - 1) g = NV - 1;
                    e_gi[i] = NI'(g);
                end
            end else if (start[i]) begin
                act[i] = 1; n[i] = 0; e_gi[i] = '0; e_busy[i] = 1; e_done[i] = 0;
                e_pass[i] = 0; e_fv[i] = '0; e_ec[i] = '0;
            end else begin
                e_done[i] = 0;
            end
        end
        if (reset) mvalid = 1'b1;
    end

    always @(negedge clk) begin
        if (mvalid) begin
            for (int i = 0; i < 2; i++) begin
                check($sformatf("gate_in[%0d]", i),   32'(gi[i]),   32'(e_gi[i]));
                check($sformatf("busy[%0d]", i),      32'(busy[i]), 32'(e_busy[i]));
                check($sformatf("done[%0d]", i),      32'(done[i]), 32'(e_done[i]));
                check($sformatf("pass[%0d]", i),      32'(pass[i]), 32'(e_pass[i]));
                check($sformatf("fail_vec[%0d]", i),  32'(fv[i]),   32'(e_fv[i]));
                check($sformatf("err_count[%0d]", i), 32'(ec[i]),   32'(e_ec[i]));
            end
        end
    end

    task automatic pulse_start0();
        @(negedge clk);
        start[0] = 1'b1;
        @(negedge clk);
        start[0] = 1'b0;
        t_acc = cyc;
    endtask

    task automatic wait_done0(input string nm, input int want_lat);
        int lat;
        lat = -1;
        for (int k = 0; k < 200; k++) begin
            if (done[0]) begin
                lat = cyc - t_acc;
                break;
            end
            @(negedge clk);
        end
        check({nm, " done latency"}, 32'(lat), 32'(want_lat));
    endtask

    task automatic check_result0(input string nm, input logic p, input logic [3:0] f, input logic [2:0] e);
        check({nm, " pass"},      32'(pass[0]), 32'(p));
        check({nm, " fail_vec"},  32'(fv[0]),   32'(f));
        check({nm, " err_count"}, 32'(ec[0]),   32'(e));
    endtask

    initial begin
        logic        xt;
        logic [15:0] seq;
        int          d1, d2, a1, idle_cnt, dcnt;
        xt    = 1'bx;
        // A two-state simulator folds X to a level; use the wrong one instead.
        xsub  = $isunknown(xt) ? 1'bx : 1'b1;
        reset = 1'b1;
        start = 2'b00;
        repeat (3) @(negedge clk);
        check("reset gate_in",   32'(gi[0]),   32'd0);
        check("reset busy",      32'(busy[0]), 32'd0);
        check("reset err_count", 32'(ec[0]),   32'd0);
        reset = 1'b0;

        // 1: NOR, vector sequence and latency
        mode = 0;
        pulse_start0();
        seq = '0;
        for (int k = 0; k < 8; k++) begin
            seq = {seq[13:0], gi[0]};
            @(negedge clk);
        end
        check("t1 gate_in sequence", 32'(seq), 32'h05AF);
        wait_done0("t1", 9);
        check_result0("t1", 1'b1, 4'b0000, 3'd0);

        // 2: stuck-at-0
        mode = 1;
        pulse_start0();
        wait_done0("t2", 9);
        check_result0("t2", 1'b0, 4'b0001, 3'd1);

        // 3: OR in place of NOR
        mode = 2;
        pulse_start0();
        wait_done0("t3", 9);
        check_result0("t3", 1'b0, 4'b1111, 3'd4);

        // 4: SETTLE=3, start held 30 cycles
        @(negedge clk);
        start[1] = 1'b1;
        a1 = cyc + 1;
        d1 = 0; d2 = 0; idle_cnt = 0;
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk);
            if (k == 30) start[1] = 1'b0;
            if (done[1] && d1 == 0) d1 = cyc;
            else if (done[1] && d1 != 0 && d2 == 0) d2 = cyc;
            if (d1 != 0 && d2 == 0 && !busy[1]) idle_cnt++;
        end
        check("t4 first done latency", 32'(d1 - a1), 32'd17);
        check("t4 done spacing",       32'(d2 - d1),  32'd18);
        check("t4 idle gap cycles",    32'(idle_cnt), 32'd1);
        check("t4 pass",               32'(pass[1]),  32'd1);

        // 5: reset while vector 2 settles
        mode = 0;
        pulse_start0();
        for (int k = 0; k < 50 && gi[0] != 2'd2; k++) @(negedge clk);
        check("t5 reached vector 2", 32'(gi[0]), 32'd2);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("t5 gate_in after reset", 32'(gi[0]),   32'd0);
        check("t5 busy after reset",    32'(busy[0]), 32'd0);
        check("t5 done after reset",    32'(done[0]), 32'd0);
        dcnt = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (done[0]) dcnt++;
        end
        check("t5 no done after reset", 32'(dcnt), 32'd0);
        pulse_start0();
        wait_done0("t5 resweep", 9);
        check_result0("t5 resweep", 1'b1, 4'b0000, 3'd0);

        // 6: unknown on vector 1, extra start while busy
        mode = 3;
        pulse_start0();
        repeat (2) @(negedge clk);
        start[0] = 1'b1;
        @(negedge clk);
        start[0] = 1'b0;
        wait_done0("t6", 9);
        check_result0("t6", 1'b0, 4'b0010, 3'd1);
        repeat (4) @(negedge clk);
        check("t6 idle after done", 32'(busy[0]), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
